// File: rtl/psw_key_encoder.sv
// Push-switch keypad encoder: synchronizes and debounces 14 active-low switches,
// turns press edges into key codes and queues them in a 4-entry FIFO.
module psw_key_encoder #(
  parameter int TICK_DIV = 50000,
  parameter int DEB_CNT  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] PSW,
  output logic        KEY_VALID,
  input  logic        KEY_READY,
  output logic [3:0]  KEY_CODE,
  output logic [2:0]  FIFO_CNT,
  output logic        OVF
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_CNT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CNT - 1);

  logic [13:0]   sync_a;
  logic [13:0]   sync_b;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [13:0]   pressed;
  logic [CW-1:0] smp_cnt [14];
  logic [13:0]   press_evt;
  logic          wr_en;
  logic [3:0]    wr_code;

  logic [3:0]    mem [4];
  logic [1:0]    rd_ptr;
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_next;
  logic [2:0]    cnt_next;
  logic [3:0]    head_next;
  logic          pop;
  logic          push;
  logic          drop;

  // Two-flop synchronizer; idle level of the switches is 1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_a <= 14'h3fff;
      sync_b <= 14'h3fff;
    end else begin
      sync_a <= PSW;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Debounce: the state flips after DEB_CNT consecutive differing samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pressed <= 14'h0000;
      for (int i = 0; i < 14; i++) smp_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 14; i++) begin
        if ((~sync_b[i]) != pressed[i]) begin
          if (smp_cnt[i] == CNT_LAST) begin
            pressed[i] <= ~pressed[i];
            smp_cnt[i] <= '0;
          end else begin
            smp_cnt[i] <= smp_cnt[i] + CW'(1);
          end
        end else begin
          smp_cnt[i] <= '0;
        end
      end
    end
  end

  // Press events this cycle; the lowest index wins, the rest are discarded
  always_comb begin
    wr_en   = 1'b0;
    wr_code = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      press_evt[i] = tick & ~sync_b[i] & ~pressed[i] & (smp_cnt[i] == CNT_LAST);
      wr_en        = wr_en | press_evt[i];
      wr_code      = press_evt[i] ? 4'(i) : wr_code;
    end
  end

  always_comb begin
    pop     = KEY_VALID & KEY_READY;
    push    = wr_en & ((FIFO_CNT != 3'd4) | pop);
    drop    = wr_en & (FIFO_CNT == 3'd4) & ~pop;
    rd_next = pop ? (rd_ptr + 2'd1) : rd_ptr;
    case ({push, pop})
      2'b10:   cnt_next = FIFO_CNT + 3'd1;
      2'b01:   cnt_next = FIFO_CNT - 3'd1;
      default: cnt_next = FIFO_CNT;
    endcase
    // The new head can only be the entry being written when the queue drains to it
    if (cnt_next == 3'd0) begin
      head_next = 4'd0;
    end else if (push && (rd_next == wr_ptr)) begin
      head_next = wr_code;
    end else begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      FIFO_CNT  <= 3'd0;
      KEY_VALID <= 1'b0;
      KEY_CODE  <= 4'd0;
      OVF       <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      rd_ptr    <= rd_next;
      FIFO_CNT  <= cnt_next;
      KEY_VALID <= (cnt_next != 3'd0);
      KEY_CODE  <= head_next;
      OVF       <= OVF | drop;
    end
  end

endmodule

// File: doc/psw_key_encoder.md
PSW_KEY_ENCODER -- requirements
Module: psw_key_encoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clock cycles per debounce sample tick (minimum 2).
REQ-002 SHALL have parameter DEB_CNT, default 4, consecutive equal samples needed to change debounced state (minimum 2).
REQ-003 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PSW  input  14  raw push switches, active-low (0 = pressed), asynchronous to CLK.
REQ-006 SHALL have port KEY_VALID  output  1  FIFO head holds a key event.
REQ-007 SHALL have port KEY_READY  input  1  consumer accepts head when high with KEY_VALID.
REQ-008 SHALL have port KEY_CODE  output  4  head key code; 0 when FIFO empty.
REQ-009 SHALL have port FIFO_CNT  output  3  entries queued, 0..4.
REQ-010 SHALL have port OVF  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-011 SHALL pass each PSW bit through a 2-flop synchronizer; flops reset to 1.
REQ-012 SHALL run a free-running tick counter 0..TICK_DIV-1, pulsing tick for one cycle when the count equals TICK_DIV-1, then wrapping to 0.
REQ-013 SHALL keep, per switch, a debounced state (reset = released) and a sample counter; sampling occurs only on tick cycles.
REQ-014 On a tick, sample differing from debounced state -> counter +1; sample equal -> counter cleared to 0.
REQ-015 When the counter reaches DEB_CNT, the debounced state SHALL flip and the counter SHALL clear.
REQ-016 A released->pressed flip SHALL generate a press event; a pressed->released flip SHALL generate no event.
REQ-017 Code map: PSW[9:0] -> 0..9 (digits), PSW[10] -> 10 (=), PSW[11] -> 11 (clear), PSW[12] -> 12 (-), PSW[13] -> 13 (+); codes 14/15 never produced.
REQ-018 Several press events on the same tick: only the lowest PSW index SHALL be enqueued; the others are discarded, and those switches still update their debounced state (no later event until released and re-pressed).
REQ-019 Press event SHALL be written to a 4-entry FIFO at the clock edge ending the tick cycle; KEY_VALID/KEY_CODE/FIFO_CNT reflect it on the next cycle (all registered outputs).
REQ-020 Pop SHALL occur on each edge where KEY_VALID=1 and KEY_READY=1; next entry, if any, presented the following cycle.
REQ-021 KEY_READY while KEY_VALID=0 SHALL have no effect; KEY_CODE SHALL hold stable while KEY_VALID=1 and no pop occurs.
REQ-022 Write with FIFO_CNT=4 and no pop in the same cycle: event dropped, FIFO unchanged, OVF set to 1.
REQ-023 Write with FIFO_CNT=4 and a pop in the same cycle: write accepted, FIFO_CNT stays 4, OVF unchanged.
REQ-024 Simultaneous write and pop at any other count SHALL leave FIFO_CNT unchanged and preserve order.
REQ-025 FIFO SHALL be strictly first-in first-out, with read and write pointers wrapping modulo 4.
REQ-026 OVF SHALL clear only by reset.

Reset
REQ-027 RST=1 SHALL immediately force KEY_VALID=0, KEY_CODE=0, FIFO_CNT=0, OVF=0, and clear pointers, tick counter and sample counters; synchronizers and debounced states go to released.
REQ-028 RST asserted mid-debounce or mid-transfer SHALL discard all in-progress and queued events.
REQ-029 After RST deassertion, a switch already held low SHALL produce a press event after a normal debounce.

Verification (TICK_DIV=2, DEB_CNT=3)
REQ-030 Bench SHALL cover: PSW[1]=0 held 40 cycles, KEY_READY=1 -> exactly one KEY_VALID pulse, KEY_CODE=1; no event when PSW[1] is released.
REQ-031 Bench SHALL cover: PSW[5] toggling every cycle for 12 cycles, then stable low -> exactly one event, code 5.
REQ-032 Bench SHALL cover: KEY_READY=0, then sequential presses of PSW[1], PSW[13], PSW[2], PSW[10] -> FIFO_CNT=4; raising KEY_READY pops codes 1, 13, 2, 10 in order, then KEY_VALID=0 and KEY_CODE=0.
REQ-033 Bench SHALL cover: FIFO full, KEY_READY=0, press PSW[11] -> OVF=1, FIFO_CNT=4, code 11 never appears on pops.
REQ-034 Bench SHALL cover: PSW[12] and PSW[3] driven low on the same cycle -> one event, code 3; no code 12 event.
REQ-035 Bench SHALL cover: RST pulsed while 2 entries are queued and PSW[7] is held low -> outputs 0 asynchronously; after release, exactly one event with code 7.
